store_buffer: RTL and testbench

- Write-posting FIFO directly upstream of the 16-bit data memory in the single-cycle core.
- Captures stores from the execute/ALU stage and drains one per cycle into the memory write port whenever that port is not needed by a load.
- Forwards buffered store data to loads that hit a pending address, so the data memory's read path never returns stale data.

---
 rtl/store_buffer.sv | 138 +++++++++++++
 tb/tb_store_buffer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Write-posting store buffer in front of the data memory: FIFO drain into the
// memory write port plus youngest-match load forwarding. Optional macro: STORE_BUF_COALESCE_EN.

module store_buffer_match #(
  parameter int AW = 16
) (
  input  logic          vld,
  input  logic [AW-1:0] ent_addr,
  input  logic [AW-1:0] ld_addr,
  output logic          hit
);
  assign hit = vld & (ent_addr == ld_addr);
endmodule

module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int DW    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   st_valid,
  input  logic [AW-1:0]          st_addr,
  input  logic [DW-1:0]          st_data,
  output logic                   st_ready,
  input  logic [AW-1:0]          ld_addr,
  output logic                   ld_hit,
  output logic [DW-1:0]          ld_data,
  input  logic                   mem_busy,
  output logic                   mem_WE,
  output logic [AW-1:0]          mem_A,
  output logic [DW-1:0]          mem_WD,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t [DEPTH-1:0] ent_q, ent_d;
  logic [PW-1:0]      head_q, head_d, tail_q, tail_d;
  logic [PW:0]        count_q, count_d;
  logic [DEPTH-1:0]   vld, hit;
  logic               alloc, co_ok, co_wr;

  // An entry is live when its distance from head is below count.
  always_comb begin
    vld = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] off;
      off    = PW'(i) - head_q;
      vld[i] = {1'b0, off} < count_q;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_match
    store_buffer_match #(.AW(AW)) u_match (
      .vld      (vld[g]),
      .ent_addr (ent_q[g].addr),
      .ld_addr  (ld_addr),
      .hit      (hit[g])
    );
  end

  // Walk oldest to youngest so the last hit found wins.
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      logic [PW-1:0] idx;
      idx = head_q + PW'(k);
      if (hit[idx]) begin
        ld_hit  = 1'b1;
        ld_data = ent_q[idx].data;
      end
    end
  end

  assign empty  = (count_q == '0);
  assign count  = count_q;
  assign mem_WE = ~empty & ~mem_busy & ~rst;
  assign mem_A  = mem_WE ? ent_q[head_q].addr : '0;
  assign mem_WD = mem_WE ? ent_q[head_q].data : '0;

`ifdef STORE_BUF_COALESCE_EN
  logic [PW-1:0] yng;
  assign yng   = tail_q - PW'(1);
  // The youngest entry is off limits once it is the one leaving this cycle.
  assign co_ok = ~empty & (ent_q[yng].addr == st_addr) &
                 ~((count_q == (PW+1)'(1)) & mem_WE);
`else
  assign co_ok = 1'b0;
`endif

  assign st_ready = (count_q < (PW+1)'(DEPTH)) | co_ok;
  assign alloc    = st_valid & st_ready & ~co_ok;
  assign co_wr    = st_valid & co_ok;

  always_comb begin
    ent_d = ent_q;
    if (alloc) begin
      ent_d[tail_q].addr = st_addr;
      ent_d[tail_q].data = st_data;
    end
`ifdef STORE_BUF_COALESCE_EN
    if (co_wr) ent_d[yng].data = st_data;
`endif
    head_d = head_q + PW'(mem_WE);
    tail_d = tail_q + PW'(alloc);
    case ({alloc, mem_WE})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
    ent_q <= ent_d;
  end

`ifndef STORE_BUF_COALESCE_EN
  logic unused_co;
  assign unused_co = co_wr;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Randomized + directed bench for store_buffer: queue-based reference model and
// a drain monitor that pops expected memory writes in program order.

module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 16;
  localparam int DW    = 16;

  logic          clk = 1'b0, rst = 1'b1, st_valid = 1'b0, mem_busy = 1'b0;
  logic [AW-1:0] st_addr = '0, ld_addr = '0;
  logic [DW-1:0] st_data = '0;
  logic          st_ready, ld_hit, mem_WE, empty;
  logic [AW-1:0] mem_A;
  logic [DW-1:0] ld_data, mem_WD;
  logic [2:0]    count;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } st_t;

  st_t q[$];
  int  checks = 0, errors = 0;

  logic          p_rst = 1'b1, p_alloc = 1'b0, p_co = 1'b0;
  logic [AW-1:0] p_a = '0;
  logic [DW-1:0] p_d = '0;

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .st_ready(st_ready), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
    .mem_busy(mem_busy), .mem_WE(mem_WE), .mem_A(mem_A), .mem_WD(mem_WD),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory-side monitor: every write must be the oldest outstanding store.
  always @(negedge clk) begin
    if (mem_WE) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL drain_unexpected: got write %0h=%0h expected none at %0t", mem_A, mem_WD, $time);
      end else begin
        chk("drain_addr", mem_A, q[0].a);
        chk("drain_data", mem_WD, q[0].d);
        void'(q.pop_front());
      end
    end
  end

  task automatic cyc(input logic r, input logic v, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic b, input logic [AW-1:0] la);
    int            n;
    bit            co, rdy, we, hit;
    logic [DW-1:0] fd;
    @(posedge clk);
    #1;
    if (p_rst) q.delete();
    else begin
      if (p_alloc) q.push_back('{p_a, p_d});
      if (p_co) q[q.size()-1].d = p_d;
    end
    rst = r; st_valid = v; st_addr = a; st_data = d; mem_busy = b; ld_addr = la;
    #1;
    n  = q.size();
    we = !r && n > 0 && !b;
    co = 1'b0;
`ifdef STORE_BUF_COALESCE_EN
    if (n > 0 && q[n-1].a == a && !(n == 1 && we)) co = 1'b1;
`endif
    rdy = (n < DEPTH) || co;
    hit = 1'b0;
    fd  = '0;
    foreach (q[i]) if (q[i].a == la) begin hit = 1'b1; fd = q[i].d; end
    if (r) chk("rst_mem_we", mem_WE, 0);
    else begin
      chk("st_ready", st_ready, rdy);
      chk("count", count, n);
      chk("empty", empty, n == 0);
      chk("mem_we", mem_WE, we);
      chk("ld_hit", ld_hit, hit);
      chk("ld_data", ld_data, fd);
      if (!we) begin
        chk("mem_a_idle", mem_A, 0);
        chk("mem_wd_idle", mem_WD, 0);
      end
    end
    p_rst   = r;
    p_alloc = !r && v && rdy && !co;
    p_co    = !r && v && co;
    p_a     = a;
    p_d     = d;
  endtask

  task automatic idle(input int n, input logic b);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, '0, b, '0);
  endtask

  initial begin
    cyc(1'b1, 1'b0, '0, '0, 1'b0, '0);
    cyc(1'b1, 1'b0, '0, '0, 1'b0, '0);
    idle(5, 1'b0);

    // Fill while the port is busy, try to overfill, then drain in order.
    cyc(1'b0, 1'b1, 16'h0010, 16'hAAAA, 1'b1, 16'h0010);
    cyc(1'b0, 1'b1, 16'h0011, 16'hBBBB, 1'b1, 16'h0010);
    cyc(1'b0, 1'b1, 16'h0012, 16'hCCCC, 1'b1, 16'h0011);
    cyc(1'b0, 1'b1, 16'h0013, 16'hDDDD, 1'b1, 16'h0012);
    cyc(1'b0, 1'b1, 16'h0099, 16'h9999, 1'b1, 16'h0013);
    cyc(1'b0, 1'b1, 16'h0098, 16'h9898, 1'b1, 16'h0099);
    idle(6, 1'b0);

    // Youngest duplicate wins forwarding.
    cyc(1'b0, 1'b1, 16'h0020, 16'h1111, 1'b1, 16'h0020);
    cyc(1'b0, 1'b1, 16'h0020, 16'h2222, 1'b1, 16'h0020);
    cyc(1'b0, 1'b0, '0, '0, 1'b1, 16'h0020);
    cyc(1'b0, 1'b0, '0, '0, 1'b1, 16'h0021);
    cyc(1'b0, 1'b0, '0, '0, 1'b0, 16'h0020);
    idle(3, 1'b0);

    // Back-to-back stores with free drain: pointers wrap repeatedly.
    for (int i = 0; i < 10; i++)
      cyc(1'b0, 1'b1, AW'(i), DW'($urandom), 1'b0, AW'(i));
    idle(3, 1'b0);

    // Reset mid-drain drops the remaining entries.
    cyc(1'b0, 1'b1, 16'h0040, 16'h4040, 1'b1, '0);
    cyc(1'b0, 1'b1, 16'h0041, 16'h4141, 1'b1, '0);
    cyc(1'b0, 1'b1, 16'h0042, 16'h4242, 1'b1, '0);
    cyc(1'b0, 1'b0, '0, '0, 1'b0, 16'h0041);
    cyc(1'b1, 1'b0, '0, '0, 1'b0, '0);
    idle(4, 1'b0);

    // Full buffer, store to the youngest address.
    cyc(1'b0, 1'b1, 16'h002D, 16'h0D0D, 1'b1, '0);
    cyc(1'b0, 1'b1, 16'h002E, 16'h0E0E, 1'b1, '0);
    cyc(1'b0, 1'b1, 16'h002F, 16'h0F0F, 1'b1, '0);
    cyc(1'b0, 1'b1, 16'h0030, 16'h3030, 1'b1, '0);
    cyc(1'b0, 1'b1, 16'h0030, 16'h5555, 1'b1, 16'h0030);
    cyc(1'b0, 1'b0, '0, '0, 1'b1, 16'h0030);
    idle(6, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      logic r;
      r = ($urandom_range(0, 199) == 0);
      cyc(r, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom),
          ($urandom_range(0, 2) == 0), AW'($urandom_range(0, 7)));
    end
    idle(8, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
